// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store memory access unit.
package mem_access_pkg;

  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef logic [DEF_TAG_W-1:0]  tag_t;
  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  // Width of the word index into a memory of 'depth' words.
  function automatic int word_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read.
module data_mem
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = word_idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage arrays carry no reset; only control state is reset, so this maps onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_access_unit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the slot after the last grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;

  // NOTE: every output of this always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    o_grant    = '0;
    w_next_ptr = r_ptr;
    if (i_en) begin
      // Scan farthest-first so the slot nearest the pointer is the one left standing.
      for (int k = N - 1; k >= 0; k--) begin
        if (i_req[(int'(r_ptr) + k) % N]) begin
          o_grant                          = '0;
          o_grant[(int'(r_ptr) + k) % N]   = 1'b1;
          w_next_ptr = PTR_W'((int'(r_ptr) + k + 1) % N);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_ptr <= '0;
    else if (|o_grant) r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store memory access unit: RR among loads, loads over stores, per-slot result hold.
// Optional store starvation guard enabled by defining MEM_ACCESS_STARVE_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int NUM_LOADS    = 2,
  parameter int NUM_STORES   = 2,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MEM_DEPTH    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_LOADS-1:0]                ld_req,
  input  logic [NUM_LOADS-1:0][ADDR_W-1:0]    ld_addr,
  input  logic [NUM_LOADS-1:0][TAG_W-1:0]     ld_tag,
  output logic [NUM_LOADS-1:0]                ld_ack,
  input  logic [NUM_STORES-1:0]               st_req,
  input  logic [NUM_STORES-1:0][ADDR_W-1:0]   st_addr,
  input  logic [NUM_STORES-1:0][DATA_W-1:0]   st_data,
  output logic [NUM_STORES-1:0]               st_ack,
  output logic [NUM_LOADS-1:0]                res_valid,
  output logic [NUM_LOADS-1:0][DATA_W-1:0]    res_data,
  output logic [NUM_LOADS-1:0][TAG_W-1:0]     res_tag,
  input  logic                                cdb_valid,
  input  logic [TAG_W-1:0]                    cdb_tag
);

  localparam int IDX_W = word_idx_w(MEM_DEPTH);

  logic [NUM_LOADS-1:0]              r_res_valid;
  logic [NUM_LOADS-1:0][DATA_W-1:0]  r_res_data;
  logic [NUM_LOADS-1:0][TAG_W-1:0]   r_res_tag;

  logic [NUM_LOADS-1:0]  w_ld_elig;
  logic [NUM_STORES-1:0] w_st_pick;
  logic                  w_any_ld;
  logic                  w_any_st;
  logic                  w_force_st;
  logic [ADDR_W-1:0]     w_raddr;
  logic [ADDR_W-1:0]     w_waddr;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_rdata;

  assign w_ld_elig = ld_req & ~r_res_valid;
  assign w_any_ld  = |w_ld_elig;
  assign w_any_st  = |st_req;

  always_comb begin
    w_st_pick = '0;
    for (int j = NUM_STORES - 1; j >= 0; j--) begin
      if (st_req[j]) begin
        w_st_pick    = '0;
        w_st_pick[j] = 1'b1;
      end
    end
  end

`ifdef MEM_ACCESS_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_st = w_any_st && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_starve_cnt <= '0;
    else if (|st_ack || !w_any_st)    r_starve_cnt <= '0;
    else if (|ld_ack && (r_starve_cnt != CNT_W'(STARVE_LIMIT)))
                                      r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  assign w_force_st = 1'b0;
`endif

  rr_arbiter #(.N(NUM_LOADS)) u_ld_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (rst_n && !w_force_st),
    .i_req   (w_ld_elig),
    .o_grant (ld_ack)
  );

  assign st_ack = (rst_n && (w_force_st || !w_any_ld)) ? w_st_pick : '0;

  always_comb begin
    w_raddr = '0;
    w_waddr = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_LOADS; i++)  if (ld_ack[i]) w_raddr = ld_addr[i];
    for (int j = 0; j < NUM_STORES; j++) begin
      if (st_ack[j]) begin
        w_waddr = st_addr[j];
        w_wdata = st_data[j];
      end
    end
  end

  // Byte offset dropped, upper bits truncated: addresses wrap modulo the memory size.
  data_mem #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (|st_ack),
    .i_waddr (IDX_W'(w_waddr >> 2)),
    .i_wdata (w_wdata),
    .i_raddr (IDX_W'(w_raddr >> 2)),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
    end else begin
      for (int i = 0; i < NUM_LOADS; i++) begin
        if (ld_ack[i]) begin
          r_res_valid[i] <= 1'b1;
          r_res_data[i]  <= w_rdata;
          r_res_tag[i]   <= ld_tag[i];
        end else if (r_res_valid[i] && cdb_valid && (cdb_tag == r_res_tag[i])) begin
          r_res_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_tag   = r_res_tag;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with default parameters (2 loads, 2 stores, 256 words).
module tb_mem_access_unit;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        ld_req;
  logic [1:0][31:0]  ld_addr;
  logic [1:0][3:0]   ld_tag;
  logic [1:0]        ld_ack;
  logic [1:0]        st_req;
  logic [1:0][31:0]  st_addr;
  logic [1:0][31:0]  st_data;
  logic [1:0]        st_ack;
  logic [1:0]        res_valid;
  logic [1:0][31:0]  res_data;
  logic [1:0][3:0]   res_tag;
  logic              cdb_valid;
  logic [3:0]        cdb_tag;

  int n_checks = 0;
  int n_errors = 0;
  bit starve_en;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_tag    (ld_tag),
    .ld_ack    (ld_ack),
    .st_req    (st_req),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ack    (st_ack),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef MEM_ACCESS_STARVE_EN
    starve_en = 1'b1;
`else
    starve_en = 1'b0;
`endif
    rst_n = 1'b0; ld_req = 2'b01; st_req = 2'b01;
    ld_addr = '0; ld_tag = '0; st_addr = '0; st_data = '0;
    cdb_valid = 1'b0; cdb_tag = '0;
    #1;
    check("rst_ld_ack", ld_ack, 2'b00);
    check("rst_st_ack", st_ack, 2'b00);
    tick(); tick();
    check("rst_res_valid", res_valid, 2'b00);
    check("rst_ld_ack2", ld_ack, 2'b00);

    // Store a word to 0x0, then reset again: memory keeps it, results are dropped.
    rst_n = 1'b1; ld_req = 2'b00;
    st_addr[0] = 32'h0; st_data[0] = 32'hCAFEF00D; st_req = 2'b01; #1;
    check("pre_store_ack", st_ack, 2'b01);
    tick(); st_req = 2'b00;
    rst_n = 1'b0; tick(); tick();
    check("rst2_res_valid", res_valid, 2'b00);
    rst_n = 1'b1;
    ld_addr[0] = 32'h0; ld_tag[0] = 4'h1; ld_req = 2'b01; #1;
    check("load0_ack", ld_ack, 2'b01);
    tick(); ld_req = 2'b00;
    check("load0_valid", res_valid, 2'b01);
    check("load0_data", res_data[0], 32'hCAFEF00D);
    check("load0_tag", res_tag[0], 4'h1);
    cdb_valid = 1'b1; cdb_tag = 4'h2; tick();
    check("cdb_miss_hold", res_valid, 2'b01);
    cdb_tag = 4'h1; tick(); cdb_valid = 1'b0;
    check("cdb_hit_clear", res_valid, 2'b00);

    // Store then load with read-after-write in the next cycle.
    st_addr[1] = 32'h40; st_data[1] = 32'hDEADBEEF; st_req = 2'b10; #1;
    check("st40_ack", st_ack, 2'b10);
    tick(); st_req = 2'b00;
    ld_addr[1] = 32'h40; ld_tag[1] = 4'h3; ld_req = 2'b10; #1;
    check("ld40_ack", ld_ack, 2'b10);
    tick(); ld_req = 2'b00;
    check("ld40_valid", res_valid, 2'b10);
    check("ld40_data", res_data[1], 32'hDEADBEEF);
    check("ld40_tag", res_tag[1], 4'h3);
    cdb_valid = 1'b1; cdb_tag = 4'h4; tick();
    check("ld40_hold", res_valid, 2'b10);
    cdb_tag = 4'h3; tick(); cdb_valid = 1'b0;
    check("ld40_clear", res_valid, 2'b00);

    // Wrap: 0x400 aliases word 0; 0x402 differs only in byte offset.
    st_addr[0] = 32'h400; st_data[0] = 32'h11223344; st_req = 2'b01; #1;
    tick(); st_req = 2'b00;
    ld_addr[0] = 32'h0; ld_tag[0] = 4'h6; ld_req = 2'b01; #1;
    tick(); ld_req = 2'b00;
    check("wrap_data", res_data[0], 32'h11223344);
    ld_addr[1] = 32'h402; ld_tag[1] = 4'h6; ld_req = 2'b10; #1;
    check("offset_ack", ld_ack, 2'b10);
    tick(); ld_req = 2'b00;
    check("offset_data", res_data[1], 32'h11223344);
    check("both_valid", res_valid, 2'b11);
    cdb_valid = 1'b1; cdb_tag = 4'h6; tick(); cdb_valid = 1'b0;
    check("multi_release", res_valid, 2'b00);

    // Busy slot: full load slot 0 cannot win, so the store goes.
    ld_addr[0] = 32'h0; ld_tag[0] = 4'h8; ld_req = 2'b01; #1;
    tick();
    st_addr[0] = 32'h80; st_data[0] = 32'h55AA55AA; st_req = 2'b01; #1;
    check("busy_ld_ack", ld_ack, 2'b00);
    check("busy_st_ack", st_ack, 2'b01);
    tick(); st_req = 2'b00; ld_req = 2'b00;
    // Grant on slot 1 alongside release of slot 0.
    ld_addr[1] = 32'h80; ld_tag[1] = 4'h9; ld_req = 2'b10;
    cdb_valid = 1'b1; cdb_tag = 4'h8; #1;
    check("indep_ack", ld_ack, 2'b10);
    tick(); ld_req = 2'b00;
    check("indep_valid", res_valid, 2'b10);
    check("indep_data", res_data[1], 32'h55AA55AA);
    cdb_tag = 4'h9; tick(); cdb_valid = 1'b0;
    check("indep_clear", res_valid, 2'b00);

    // Round-robin: both requesting, each result freed the cycle after it lands.
    ld_addr[0] = 32'h40; ld_addr[1] = 32'h40;
    ld_tag[0] = 4'h1; ld_tag[1] = 4'h2; ld_req = 2'b11; #1;
    check("rr_grant1", ld_ack, 2'b01);
    tick(); cdb_valid = 1'b1; cdb_tag = 4'h1; #1;
    check("rr_grant2", ld_ack, 2'b10);
    tick(); cdb_tag = 4'h2; #1;
    check("rr_grant3", ld_ack, 2'b01);
    tick(); cdb_tag = 4'h1; #1;
    check("rr_grant4", ld_ack, 2'b10);
    tick(); ld_req = 2'b00; cdb_tag = 4'h2; tick(); cdb_valid = 1'b0;
    check("rr_drain", res_valid, 2'b00);

    // Starvation: loads stay eligible, store on slot 1 pending.
    ld_tag[0] = 4'h5; ld_tag[1] = 4'h5; cdb_valid = 1'b1; cdb_tag = 4'h5;
    st_addr[1] = 32'hC0; st_data[1] = 32'h0BADF00D;
    ld_req = 2'b11; st_req = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("starve_st_c%0d", c), st_ack, (starve_en && c == 5) ? 2'b10 : 2'b00);
      check($sformatf("starve_ld_c%0d", c), |ld_ack, !(starve_en && c == 5));
      tick();
    end
    ld_req = 2'b00;
    if (!starve_en) begin
      #1;
      check("starve_off_st", st_ack, 2'b10);
      tick();
    end
    st_req = 2'b00;
    tick(); tick(); cdb_valid = 1'b0;
    check("starve_drain", res_valid, 2'b00);
    ld_addr[0] = 32'hC0; ld_tag[0] = 4'h2; ld_req = 2'b01; #1;
    tick(); ld_req = 2'b00;
    check("starve_store_data", res_data[0], 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store memory access unit for the Tomasulo core. It sits between the load and store buffers and the data memory. Each cycle it grants one pending request under a fixed scheme: round-robin among loads, loads over stores, and an optional store starvation guard. It holds each load result in a per-slot register until the CDB broadcasts that load's tag.

## Interface
Parameters:
- NUM_LOADS, 2, number of load buffer slots (1..8)
- NUM_STORES, 2, number of store buffer slots (1..8)
- TAG_W, 4, RS/buffer tag width
- DATA_W, 32, data width
- ADDR_W, 32, byte address width
- MEM_DEPTH, 256, data memory depth in words (power of 2)
- STARVE_LIMIT, 4, max consecutive cycles a pending store may lose to loads (used only with the macro)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- ld_req  in  NUM_LOADS  per-slot load request; held until acked
- ld_addr  in  NUM_LOADS x ADDR_W  load byte addresses
- ld_tag  in  NUM_LOADS x TAG_W  load tags
- ld_ack  out  NUM_LOADS  one-hot grant pulse
- st_req  in  NUM_STORES  per-slot store request; held until acked
- st_addr  in  NUM_STORES x ADDR_W  store byte addresses
- st_data  in  NUM_STORES x DATA_W  store data
- st_ack  out  NUM_STORES  one-hot grant pulse; write commits at this edge
- res_valid  out  NUM_LOADS  result register full
- res_data  out  NUM_LOADS x DATA_W  loaded data
- res_tag  out  NUM_LOADS x TAG_W  tag of held result
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB broadcast tag

## Operation
- Eligibility: load slot i is eligible when ld_req[i] && !res_valid[i]. Store slot j is eligible when st_req[j].
- One memory operation per cycle. ld_ack and st_ack are combinational, at most one bit set across both vectors.
- Priority: any eligible load beats any store. Round-robin among loads, starting from the slot after the last granted load. Fixed priority among stores, lowest index first.
- Load grant, slot i: memory reads ld_addr[i]. At the next edge, res_valid[i] is set, res_data[i] is loaded with the read data and res_tag[i] is loaded with ld_tag[i].
- Store grant, slot j: memory writes st_data[j] to st_addr[j] at that edge.
- Word index is addr[$clog2(MEM_DEPTH)+1:2]. Byte offset bits are ignored. Higher bits are ignored, so addresses wrap modulo the memory size.
- Release: on cdb_valid && cdb_tag == res_tag[i] with res_valid[i] set, res_valid[i] clears at the next edge. Several slots holding that tag all clear.
- A slot with res_valid set is ineligible, so grant and release never coincide on one slot. Grant on slot a with release on slot b in the same cycle are independent.
- No idle grant: with no eligible requester, acks are 0, there is no write, and the RR pointer holds.
- Reset: res_valid=0, res_data=0, res_tag=0, RR pointer=0, starvation counter=0. Memory contents are not reset. Acks are 0 while rst_n=0. Reset mid-operation drops all held results; memory writes from edges before reset persist.

## Timing
- Load latency: ld_ack at edge N, res_valid=1 after edge N. Back-to-back loads to different slots give 1 grant per cycle.
- The requester must deassert or change ld_req / st_req in the cycle after its ack. A request still high after its ack is treated as a new request.
- Read-after-write: a store at edge N is visible to a load granted in cycle N+1.
- res_* are stable while res_valid is set.

## Configuration
- MEM_ACCESS_STARVE_EN defined: a counter increments each cycle a store is eligible but a load is granted, saturating at STARVE_LIMIT. It resets on any store grant or when no store is eligible. When the count equals STARVE_LIMIT, the lowest eligible store is granted instead of any load.
- MEM_ACCESS_STARVE_EN undefined: strict load priority, with no counter logic.

## Structure
- Package mem_access_pkg holds the tag_t, data_t and addr_t typedefs and the function that computes the word index width.
- Sub-module rr_arbiter (parameter N) takes a request vector and produces a one-hot grant, with an internal pointer advanced on grant. The unit instantiates it for the loads; the store pick is an inline priority encoder.
- The unit instantiates the existing data_mem, parametrised to DATA_W and MEM_DEPTH.

## Test plan
- Reset → with rst_n=0 for 2 cycles, all res_valid=0, acks=0; after release, a load from addr 0x0 returns the preloaded word.
- RR fairness → ld_req=2'b11 held, with each result freed by CDB the cycle after it appears → grants alternate 0,1,0,1.
- Store then load → store 0xDEADBEEF to 0x40, then a load with tag 4'h3 from 0x40 → res_data=0xDEADBEEF, res_tag=3; res_valid clears only on cdb_tag=3.
- Busy slot → res_valid[0]=1, ld_req[0]=1 and st_req[0]=1 → store granted, not load 0.
- Wrap → with MEM_DEPTH=256, a store to 0x400 followed by a load from 0x0 returns the stored value.
- Starvation (macro on, STARVE_LIMIT=4) → st_req[1] held while loads keep eligible → st_ack[1] in the 5th cycle; with the macro off, no store grant until loads stop.
